// File: rtl/i2c_read_poll_pkg.sv
// Purpose: shared types and constants for the I2C read-poll sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2c_read_poll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PERIOD    = 3'd1,
        ST_GO_HI     = 3'd2,
        ST_WAIT_RUN  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_CHECK     = 3'd5,
        ST_BACKOFF   = 3'd6
    } state_t;

    // Counter widths
    localparam int PER_W = 20;
    localparam int TMO_W = 13;
    localparam int GO_W  = 8;
    localparam int BO_W  = 5;

    // Cycles spent in BACKOFF between a failed attempt and the retry
    localparam int BACKOFF_LEN = 16;

    // IDLE and PERIOD are the only states where the engine is not in use
    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_PERIOD));
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Purpose: loadable down-counter with terminal-count flag, saturating at zero.
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; counts every cycle it is not being loaded.
// Ports: clk/rst (sync, active-high), load + load_val (reload), tc (count == 0).
module poll_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/i2c_read_poll.sv
// Purpose: triggers a downstream I2C read engine on request or periodically, retries on NACK/timeout.
// Latency: RD_VALID rises 1 cycle after END_OK rises on an acked read; RD_DATA is valid with it.
// Backpressure: REQ is accepted only in IDLE; a REQ while BUSY is dropped, never queued.
// Ports: PT_CK/RESET clock and sync reset; AUTO/REQ/SLAVE_ADDR_IN/NBYTE_IN control in;
//        SLAVE_ADDRESS/END_BYTE/GO to engine; END_OK/ACK_OK/DATA16 from engine;
//        RD_DATA/RD_VALID/RD_ERR/BUSY/RETRY_CNT status out.
module i2c_read_poll
    import i2c_read_poll_pkg::*;
#(
    parameter int GO_CYCLES   = 4,
    parameter int POLL_PERIOD = 50000,
    parameter int TIMEOUT     = 4096,
    parameter int MAX_RETRY   = 3
) (
    input  logic        PT_CK,
    input  logic        RESET,
    input  logic        AUTO,
    input  logic        REQ,
    input  logic [7:0]  SLAVE_ADDR_IN,
    input  logic [7:0]  NBYTE_IN,
    output logic [7:0]  SLAVE_ADDRESS,
    output logic [7:0]  END_BYTE,
    output logic        GO,
    input  logic        END_OK,
    input  logic        ACK_OK,
    input  logic [15:0] DATA16,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic        RD_ERR,
    output logic        BUSY,
    output logic [3:0]  RETRY_CNT
);

    // Timers are loaded with (length - 1) so tc marks the last cycle of the state
    localparam logic [GO_W-1:0]  GO_LOAD   = GO_W'(GO_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LOAD  = PER_W'(POLL_PERIOD - 1);
    localparam logic [BO_W-1:0]  BO_LOAD   = BO_W'(BACKOFF_LEN - 1);
    localparam logic [3:0]       MAX_RETRY_C = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  nbyte_q, nbyte_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [3:0]  retry_q, retry_d;
    logic        ack_q, ack_d;

    logic go_tc, tmo_tc, per_tc, bo_tc;
    logic go_load, tmo_load, per_load, bo_load;
    logic state_chg;

    // Every timer restarts on entry to the state it times
    assign state_chg = (state_d != state_q);
    assign go_load   = state_chg && (state_d == ST_GO_HI);
    assign tmo_load  = state_chg && ((state_d == ST_WAIT_RUN) || (state_d == ST_WAIT_DONE));
    assign per_load  = state_chg && (state_d == ST_PERIOD);
    assign bo_load   = state_chg && (state_d == ST_BACKOFF);

    poll_timer #(.W(GO_W))  u_go_tmr  (.clk(PT_CK), .rst(RESET), .load(go_load),  .load_val(GO_LOAD),  .tc(go_tc));
    poll_timer #(.W(TMO_W)) u_tmo_tmr (.clk(PT_CK), .rst(RESET), .load(tmo_load), .load_val(TMO_LOAD), .tc(tmo_tc));
    poll_timer #(.W(PER_W)) u_per_tmr (.clk(PT_CK), .rst(RESET), .load(per_load), .load_val(PER_LOAD), .tc(per_tc));
    poll_timer #(.W(BO_W))  u_bo_tmr  (.clk(PT_CK), .rst(RESET), .load(bo_load),  .load_val(BO_LOAD),  .tc(bo_tc));

    // State and datapath registers
    always_ff @(posedge PT_CK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            nbyte_q   <= '0;
            rd_data_q <= '0;
            retry_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nbyte_q   <= nbyte_d;
            rd_data_q <= rd_data_d;
            retry_q   <= retry_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state logic; a real END_OK edge wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (REQ || AUTO) state_d = ST_GO_HI;
            ST_PERIOD:    if (!AUTO) state_d = ST_IDLE;
                          else if (per_tc) state_d = ST_GO_HI;
            ST_GO_HI:     if (go_tc) state_d = ST_WAIT_RUN;
            ST_WAIT_RUN:  if (!END_OK) state_d = ST_WAIT_DONE;
                          else if (tmo_tc) state_d = ST_CHECK;
            ST_WAIT_DONE: if (END_OK || tmo_tc) state_d = ST_CHECK;
            ST_CHECK: begin
                if (!ack_q && (retry_q < MAX_RETRY_C)) state_d = ST_BACKOFF;
                else if (AUTO) state_d = ST_PERIOD;
                else state_d = ST_IDLE;
            end
            ST_BACKOFF:   if (bo_tc) state_d = ST_GO_HI;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_d    = addr_q;
        nbyte_d   = nbyte_q;
        rd_data_d = rd_data_q;
        retry_d   = retry_q;
        ack_d     = ack_q;

        // New transaction (not a retry): re-latch target and restart retry count
        if (((state_q == ST_IDLE) || (state_q == ST_PERIOD)) && (state_d == ST_GO_HI)) begin
            addr_d  = SLAVE_ADDR_IN;
            nbyte_d = NBYTE_IN;
            retry_d = '0;
        end

        case (state_q)
            ST_GO_HI: ack_d = 1'b0;
            ST_WAIT_RUN: begin
                if (!END_OK || tmo_tc) ack_d = 1'b0;
            end
            ST_WAIT_DONE: begin
                if (END_OK) begin
                    // Capture on entry to CHECK so RD_DATA lines up with RD_VALID
                    if (ack_q) rd_data_d = DATA16;
                end else if (tmo_tc) begin
                    ack_d = 1'b0;
                end else if (ACK_OK) begin
                    ack_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (!ack_q && (retry_q < MAX_RETRY_C)) retry_d = retry_q + 4'd1;
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        GO            = (state_q == ST_GO_HI);
        BUSY          = is_busy(state_q);
        RD_VALID      = (state_q == ST_CHECK) && ack_q;
        RD_ERR        = (state_q == ST_CHECK) && !ack_q && (retry_q >= MAX_RETRY_C);
        RD_DATA       = rd_data_q;
        RETRY_CNT     = retry_q;
        SLAVE_ADDRESS = addr_q;
        END_BYTE      = nbyte_q;
    end

endmodule

// File: tb/tb_i2c_read_poll.sv
module tb_i2c_read_poll;

    logic        PT_CK = 1'b0;
    logic        RESET, AUTO, REQ;
    logic [7:0]  SLAVE_ADDR_IN, NBYTE_IN, SLAVE_ADDRESS, END_BYTE;
    logic        GO, END_OK, ACK_OK;
    logic [15:0] DATA16, RD_DATA;
    logic        RD_VALID, RD_ERR, BUSY;
    logic [3:0]  RETRY_CNT;

    i2c_read_poll #(.GO_CYCLES(4), .POLL_PERIOD(100), .TIMEOUT(64), .MAX_RETRY(3)) dut (
        .PT_CK(PT_CK), .RESET(RESET), .AUTO(AUTO), .REQ(REQ),
        .SLAVE_ADDR_IN(SLAVE_ADDR_IN), .NBYTE_IN(NBYTE_IN),
        .SLAVE_ADDRESS(SLAVE_ADDRESS), .END_BYTE(END_BYTE), .GO(GO),
        .END_OK(END_OK), .ACK_OK(ACK_OK), .DATA16(DATA16),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_ERR(RD_ERR),
        .BUSY(BUSY), .RETRY_CNT(RETRY_CNT)
    );

    always #5 PT_CK = ~PT_CK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge PT_CK) cyc <= cyc + 1;

    // Monitor counters, sampled on the falling edge
    int   rdv_cnt = 0, rderr_cnt = 0, both_cnt = 0, go_rise_cnt = 0;
    int   go_len_cur = 0, go_len_last = 0, go_last_rise = 0, rdv_cyc = 0;
    logic go_prev = 1'b0;

    always @(negedge PT_CK) begin
        if (RD_VALID === 1'b1) begin rdv_cnt++; rdv_cyc = cyc; end
        if (RD_ERR === 1'b1) rderr_cnt++;
        if ((RD_VALID === 1'b1) && (RD_ERR === 1'b1)) both_cnt++;
        if (GO === 1'b1) begin
            if (!go_prev) begin go_rise_cnt++; go_last_rise = cyc; go_len_cur = 0; end
            go_len_cur++;
        end else if (go_prev) begin
            go_len_last = go_len_cur;
        end
        go_prev = (GO === 1'b1);
    end

    // Engine model: after each GO pulse, runs for 3 cycles (unless hung), acks or nacks
    int          eng_nack_left = 0;
    logic        eng_hang = 1'b0;
    logic [15:0] eng_data = 16'h0000;
    int          endok_cyc = 0;

    initial begin
        END_OK = 1'b1; ACK_OK = 1'b0; DATA16 = 16'h0000;
        forever begin
            do @(negedge PT_CK); while (GO !== 1'b1);
            do @(negedge PT_CK); while (GO !== 1'b0);
            if (!eng_hang) begin
                END_OK = 1'b0;
                ACK_OK = (eng_nack_left == 0);
                repeat (3) @(negedge PT_CK);
                if (eng_nack_left > 0) begin
                    eng_nack_left--;
                    DATA16 = 16'hDEAD;
                end else begin
                    DATA16 = eng_data;
                end
                END_OK = 1'b1;
                ACK_OK = 1'b0;
                endok_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PT_CK);
        #1;
    endtask

    function automatic int sel_cnt(input int which);
        case (which)
            0:       return rdv_cnt;
            1:       return rderr_cnt;
            default: return go_rise_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while ((sel_cnt(which) < target) && (n < budget)) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(sel_cnt(which) >= target), 32'd1);
    endtask

    int rdv0, err0, go0, r1, r2, r3, n;

    initial begin
        RESET = 1'b1; AUTO = 1'b0; REQ = 1'b0;
        SLAVE_ADDR_IN = 8'h00; NBYTE_IN = 8'h00;
        repeat (3) tick();
        check("rst_go", GO, 0);
        check("rst_rd_data", RD_DATA, 0);
        check("rst_rd_valid", RD_VALID, 0);
        check("rst_rd_err", RD_ERR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_retry", RETRY_CNT, 0);
        check("rst_addr", SLAVE_ADDRESS, 0);
        check("rst_nbyte", END_BYTE, 0);
        RESET = 1'b0;
        tick();

        // Single acked read; a second REQ while busy must be dropped
        rdv0 = rdv_cnt; err0 = rderr_cnt; go0 = go_rise_cnt;
        eng_data = 16'hA55A;
        SLAVE_ADDR_IN = 8'h6C; NBYTE_IN = 8'h02;
        REQ = 1'b1; tick(); REQ = 1'b0;
        SLAVE_ADDR_IN = 8'h00; NBYTE_IN = 8'h00;
        tick();
        check("s1_busy", BUSY, 1);
        check("s1_go", GO, 1);
        check("s1_addr", SLAVE_ADDRESS, 8'h6C);
        check("s1_nbyte", END_BYTE, 8'h02);
        SLAVE_ADDR_IN = 8'h11;
        REQ = 1'b1; tick(); REQ = 1'b0;
        wait_cnt("s1_rdv", 0, rdv0 + 1, 200);
        check("s1_rd_valid", RD_VALID, 1);
        check("s1_rd_data", RD_DATA, 16'hA55A);
        check("s1_retry", RETRY_CNT, 0);
        check("s1_latency", 32'(rdv_cyc - endok_cyc), 1);
        check("s1_go_len", 32'(go_len_last), 4);
        repeat (40) tick();
        check("s1_rdv_once", 32'(rdv_cnt - rdv0), 1);
        check("s1_no_err", 32'(rderr_cnt - err0), 0);
        check("s1_one_go", 32'(go_rise_cnt - go0), 1);
        check("s1_addr_kept", SLAVE_ADDRESS, 8'h6C);
        check("s1_idle", BUSY, 0);

        // Two NACKs then an ack
        rdv0 = rdv_cnt; err0 = rderr_cnt; go0 = go_rise_cnt;
        eng_nack_left = 2; eng_data = 16'h1234;
        REQ = 1'b1; tick(); REQ = 1'b0;
        wait_cnt("s2_rdv", 0, rdv0 + 1, 400);
        check("s2_rd_data", RD_DATA, 16'h1234);
        check("s2_retry", RETRY_CNT, 2);
        check("s2_go_cnt", 32'(go_rise_cnt - go0), 3);
        repeat (10) tick();
        check("s2_rdv_once", 32'(rdv_cnt - rdv0), 1);
        check("s2_no_err", 32'(rderr_cnt - err0), 0);

        // Engine never starts: four timeouts then one RD_ERR
        rdv0 = rdv_cnt; err0 = rderr_cnt; go0 = go_rise_cnt;
        eng_hang = 1'b1;
        REQ = 1'b1; tick(); REQ = 1'b0;
        wait_cnt("s3_err", 1, err0 + 1, 1000);
        check("s3_rd_err", RD_ERR, 1);
        check("s3_rd_valid", RD_VALID, 0);
        check("s3_retry", RETRY_CNT, 3);
        check("s3_rd_data", RD_DATA, 16'h1234);
        check("s3_go_cnt", 32'(go_rise_cnt - go0), 4);
        repeat (30) tick();
        check("s3_err_once", 32'(rderr_cnt - err0), 1);
        check("s3_no_rdv", 32'(rdv_cnt - rdv0), 0);
        check("s3_idle", BUSY, 0);
        eng_hang = 1'b0;

        // Auto polling: GO spacing = 100 period + 9 transaction cycles
        rdv0 = rdv_cnt; go0 = go_rise_cnt;
        eng_data = 16'h0F0F;
        AUTO = 1'b1;
        wait_cnt("s4_go1", 2, go0 + 1, 20);
        r1 = go_last_rise;
        wait_cnt("s4_go2", 2, go0 + 2, 300);
        r2 = go_last_rise;
        wait_cnt("s4_go3", 2, go0 + 3, 300);
        r3 = go_last_rise;
        check("s4_space12", 32'(r2 - r1), 109);
        check("s4_space23", 32'(r3 - r2), 109);
        wait_cnt("s4_rdv3", 0, rdv0 + 3, 100);
        check("s4_rd_data", RD_DATA, 16'h0F0F);
        check("s4_retry", RETRY_CNT, 0);
        repeat (5) tick();
        check("s4_period_not_busy", BUSY, 0);
        AUTO = 1'b0;
        repeat (300) tick();
        check("s4_no_more_go", 32'(go_rise_cnt - go0), 3);
        check("s4_idle", BUSY, 0);

        // Reset during WAIT_DONE, then a clean transaction
        rdv0 = rdv_cnt; err0 = rderr_cnt;
        eng_data = 16'hBEEF;
        REQ = 1'b1; tick(); REQ = 1'b0;
        n = 0;
        while ((END_OK !== 1'b0) && (n < 50)) begin tick(); n++; end
        check("s5_engine_started", END_OK, 0);
        tick();
        RESET = 1'b1;
        tick();
        check("s5_go_after_rst", GO, 0);
        check("s5_busy_after_rst", BUSY, 0);
        check("s5_rd_data_after_rst", RD_DATA, 0);
        RESET = 1'b0;
        tick(); tick();
        check("s5_no_pulse", 32'((rdv_cnt - rdv0) + (rderr_cnt - err0)), 0);
        REQ = 1'b1; tick(); REQ = 1'b0;
        wait_cnt("s5_rdv", 0, rdv0 + 1, 100);
        check("s5_rd_data", RD_DATA, 16'hBEEF);
        check("s5_retry", RETRY_CNT, 0);
        check("never_both", 32'(both_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
